imem_arbiter: RTL

- Owns the single-port, word-wide instruction memory (synchronous read, 1-cycle latency).
- Shares that memory between two requesters: the CPU fetch stage (read-only) and the program loader/debug port (read/write).
- Sequences boot: after reset the CPU is held stalled while the loader fills memory, then fetch is released.
- Sits between the IF stage, the loader front-end, and the memory array.

---
 rtl/imem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares a single-port, word-wide instruction memory (synchronous read,
// 1-cycle latency) between the CPU fetch stage and the program loader/debug
// port, and sequences boot: the CPU is held stalled in BOOT while the loader
// fills memory, released in RUN, and sent back through a one-cycle DRAIN when
// a reload is requested.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_ce/if_addr            fetch request and byte address
//   if_stall                 fetch not granted this cycle (combinational)
//   if_valid/if_inst         fetch return, one cycle after grant
//   ld_req/ld_we/ld_addr/    loader request (held until ld_ack)
//   ld_wdata
//   ld_ack/ld_rdata          loader completion pulse and read data
//   ld_done/ld_reload        boot image loaded / return to BOOT
//   boot_mode                1 in BOOT or DRAIN
//   mem_ce/mem_we/mem_addr/  memory port, driven combinationally by the winner
//   mem_wdata/mem_rdata
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int MEM_AW       = 17,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [31:0]       if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic [31:0]       ld_rdata,
    input  logic              ld_done,
    input  logic              ld_reload,
    output logic              boot_mode,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          if_ret_q, if_ret_d;     // fetch granted last cycle
    logic          ld_ret_q, ld_ret_d;     // loader granted last cycle
    logic          ld_ret_we_q, ld_ret_we_d;

    logic          ld_pend;
    logic          force_ld;
    logic          if_gnt;
    logic          ld_gnt;

    // ------------------------------------------------------------------
    // Grant decision and next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if_gnt   = 1'b0;
        ld_gnt   = 1'b0;
        force_ld = 1'b0;
        // A request still held during its own ack cycle is the old one
        // being dropped; it must not be granted a second time.
        ld_pend  = ld_req && !ld_ret_q;

        case (state_q)
            ST_BOOT: begin
                ld_gnt   = ld_pend;
                starve_d = '0;
                if (ld_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                force_ld = ld_pend && (starve_q == SW'(STARVE_LIMIT));
                if_gnt   = if_ce && !force_ld;
                ld_gnt   = ld_pend && (!if_ce || force_ld);
                if (ld_gnt) begin
                    starve_d = '0;
                end else if (ld_pend && (starve_q != SW'(STARVE_LIMIT))) begin
                    starve_d = starve_q + 1'b1;
                end
                // ld_done is meaningless here, so reload always wins.
                if (ld_reload) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                starve_d = '0;
                state_d  = ST_BOOT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // No memory traffic is started while reset is held.
        if (rst) begin
            if_gnt = 1'b0;
            ld_gnt = 1'b0;
        end
    end

    assign if_ret_d    = if_gnt;
    assign ld_ret_d    = ld_gnt;
    assign ld_ret_we_d = ld_gnt && ld_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            starve_q    <= '0;
            if_ret_q    <= 1'b0;
            ld_ret_q    <= 1'b0;
            ld_ret_we_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_ret_q    <= if_ret_d;
            ld_ret_q    <= ld_ret_d;
            ld_ret_we_q <= ld_ret_we_d;
        end
    end

    // ------------------------------------------------------------------
    // Requester-side outputs. Returns are masked during reset so an
    // access in flight when rst rises is dropped rather than delivered.
    // ------------------------------------------------------------------
    assign if_stall  = if_ce && !if_gnt;
    assign if_valid  = if_ret_q && !rst;
    assign if_inst   = if_valid ? mem_rdata : 32'd0;
    assign ld_ack    = ld_ret_q && !rst;
    assign ld_rdata  = (ld_ack && !ld_ret_we_q) ? mem_rdata : 32'd0;
    assign boot_mode = rst || (state_q != ST_RUN);

    // ------------------------------------------------------------------
    // Memory port, muxed from the winner. Byte addresses are truncated to
    // the word index, so addresses wrap modulo the memory size.
    // ------------------------------------------------------------------
    assign mem_ce    = if_gnt || ld_gnt;
    assign mem_we    = ld_gnt && ld_we;
    assign mem_wdata = ld_gnt ? ld_wdata : 32'd0;

    for (genvar gi = 0; gi < MEM_AW; gi++) begin : g_addr
        assign mem_addr[gi] = ld_gnt ? ld_addr[gi+2] :
                              (if_gnt ? if_addr[gi+2] : 1'b0);
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:MEM_AW+2],
                                ld_addr[1:0], ld_addr[31:MEM_AW+2]};

endmodule
